i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b0011010, the 7-bit bus address this block answers to.
REQ-002 SHALL have port clk input 1: system clock (50 MHz); all logic runs on its rising edge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port scl_i input 1: raw SCL pin level, asynchronous to clk.
REQ-005 SHALL have port sda_i input 1: raw SDA pin level, asynchronous to clk.
REQ-006 SHALL have port sda_oe output 1: when 1, the pad pulls SDA low; when 0, SDA is released (open-drain).
REQ-007 SHALL have port tx_data input 8: byte to return to the master on a read.
REQ-008 SHALL have port tx_req output 1: one-cycle pulse requesting the next tx_data.
REQ-009 SHALL have port rx_data output 8: last byte written by the master.
REQ-010 SHALL have port rx_valid output 1: one-cycle pulse when rx_data updates.
REQ-011 SHALL have port busy output 1: high while the FSM is not IDLE.

Function
REQ-012 SHALL pass scl_i and sda_i through 2-flop synchronizers plus one history flop; all edges below refer to synchronized signals, detected 3 clk after the pin change.
REQ-013 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-014 SHALL use FSM states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-015 SHALL sample SDA only on SCL rising edges, MSB first, with a bit counter of 0..7.
REQ-016 SHALL change sda_oe only on SCL falling edges, except for release on STOP or reset.
REQ-017 SHALL go to ADDR on START from any state, clear the bit counter and release sda_oe (repeated START supported).
REQ-018 SHALL go to IDLE on STOP from any state, release sda_oe, and generate no pulses.
REQ-019 SHALL compare the 7 address bits against SLAVE_ADDR after the 8th rise in ADDR (bit 8 = R/W); on mismatch, go to WAIT_STOP and never drive SDA.
REQ-020 SHALL, on address match, set sda_oe=1 at the next SCL fall (ADDR_ACK) and hold it for exactly one SCL period.
REQ-021 SHALL, if R/W=0, release sda_oe at the SCL fall ending the ACK and enter WRITE.
REQ-022 SHALL, in WRITE on the 8th rise: load rx_data, pulse rx_valid for 1 clk, then drive the ACK as in REQ-020 (WRITE_ACK), then return to WRITE.
REQ-023 SHALL, if R/W=1, pulse tx_req on the SCL rise of the address ACK bit.
REQ-024 SHALL, for a read, capture tx_data on the SCL fall ending the ACK, set sda_oe=~bit7 and enter READ.
REQ-025 SHALL, in READ, shift out the next bit on each SCL fall (sda_oe=~bit) and release sda_oe on the fall after bit 0 (READ_ACK).
REQ-026 SHALL sample the master's response on the READ_ACK rise.
REQ-027 SHALL, if that response is ACK (0), pulse tx_req on that rise and load and drive the next byte at the following fall.
REQ-028 SHALL, if that response is NACK (1), go to WAIT_STOP with sda_oe=0.
REQ-029 SHALL hold rx_data across transactions and change it only per REQ-022.
REQ-030 SHALL give priority to START/STOP detection over bit processing in the same clk.
REQ-031 SHALL use no clock stretching and SHALL NOT support general-call or 10-bit addressing.

Reset
REQ-032 SHALL, while rst_n=0, immediately set: FSM=IDLE, sda_oe=0, tx_req=0, rx_valid=0, busy=0, rx_data=8'h00, bit counter=0, shift register=0, synchronizer flops=1 (bus idle).
REQ-033 SHALL, on reset asserted mid-transfer, release SDA at once and, after deassertion, ignore the bus until the next START.

Verification
REQ-034 SHALL cover a write: START, 0x34 (addr 0x1A, W), 0xA5, STOP at 100 kHz -> ACK low on both 9th bits; one rx_valid pulse with rx_data=0xA5; busy low after STOP.
REQ-035 SHALL cover an address mismatch: START, 0x36, 0xFF, STOP -> sda_oe stays 0 throughout; no rx_valid or tx_req pulses.
REQ-036 SHALL cover a two-byte read: START, 0x35, tx_data=0x5A then 0xC3, master ACK then NACK -> SDA shows 0x5A then 0xC3; exactly 2 tx_req pulses; WAIT_STOP, then IDLE on STOP.
REQ-037 SHALL cover a repeated START: START, 0x34, 0x11, Sr, 0x35, read one byte with NACK, STOP -> rx_data=0x11; then read path taken; tx_req pulses once.
REQ-038 SHALL cover reset mid-byte: rst_n low during bit 4 of a read byte -> sda_oe=0 within the same clk; all outputs at reset values; no ACK until a new START.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit address, byte write/read, no clock stretching.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b0011010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] rx_data_n;
    logic       oe_n, tx_req_n, rx_valid_n;
    logic       rw, rw_n;

    logic scl_s1, scl_sync, scl_hist;
    logic sda_s1, sda_sync, sda_hist;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Two-flop synchronizers plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1   <= 1'b1;
            scl_sync <= 1'b1;
            scl_hist <= 1'b1;
            sda_s1   <= 1'b1;
            sda_sync <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_s1   <= scl_i;
            scl_sync <= scl_s1;
            scl_hist <= scl_sync;
            sda_s1   <= sda_i;
            sda_sync <= sda_s1;
            sda_hist <= sda_sync;
        end
    end

    assign scl_rise  =  scl_sync & ~scl_hist;
    assign scl_fall  = ~scl_sync &  scl_hist;
    assign start_det =  scl_sync & ~sda_sync &  sda_hist;
    assign stop_det  =  scl_sync &  sda_sync & ~sda_hist;
    assign busy      = (state != IDLE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shift    <= '0;
            sda_oe   <= 1'b0;
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rw       <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shift    <= shift_n;
            sda_oe   <= oe_n;
            tx_req   <= tx_req_n;
            rx_valid <= rx_valid_n;
            rx_data  <= rx_data_n;
            rw       <= rw_n;
        end
    end

    // Next-state and output logic; bus conditions take priority over bits
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shift_n    = shift;
        oe_n       = sda_oe;
        tx_req_n   = 1'b0;
        rx_valid_n = 1'b0;
        rx_data_n  = rx_data;
        rw_n       = rw;

        if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_sync};
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rw_n    = sda_sync;
                            state_n = (shift[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                end
                // sda_oe doubles as the marker that the ACK bit has begun
                ADDR_ACK: begin
                    if (scl_rise && sda_oe && rw) begin
                        tx_req_n = 1'b1;
                    end
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            oe_n = 1'b1;
                        end else if (rw) begin
                            shift_n = tx_data;
                            oe_n    = ~tx_data[7];
                            cnt_n   = '0;
                            state_n = READ;
                        end else begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_sync};
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rx_data_n  = {shift[6:0], sda_sync};
                            rx_valid_n = 1'b1;
                            state_n    = WRITE_ACK;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            oe_n = 1'b1;
                        end else begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = WRITE;
                        end
                    end
                end
                // Counter tracks falls: bits 6..0 follow bit 7, then release
                READ: begin
                    if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = READ_ACK;
                        end else begin
                            shift_n = {shift[6:0], 1'b0};
                            oe_n    = ~shift[6];
                            cnt_n   = cnt + 3'd1;
                        end
                    end
                end
                // Entered on a fall, so any fall seen here follows an ACK rise
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync) begin
                            oe_n    = 1'b0;
                            state_n = WAIT_STOP;
                        end else begin
                            tx_req_n = 1'b1;
                        end
                    end else if (scl_fall) begin
                        shift_n = tx_data;
                        oe_n    = ~tx_data[7];
                        cnt_n   = '0;
                        state_n = READ;
                    end
                end
                WAIT_STOP: begin
                    oe_n = 1'b0;
                end
                default: begin
                    oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: bus-master tasks drive SCL/SDA, wired-AND SDA with the slave.
`timescale 1ns/1ps
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rxv_cnt  = 0;
    int txr_cnt  = 0;
    int oe_cnt   = 0;
    int unsigned q = 2500;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h1A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (m_scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    // Cycle counters of the pulse outputs and SDA drive
    always @(posedge clk) begin
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (tx_req)   txr_cnt <= txr_cnt + 1;
        if (sda_oe)   oe_cnt  <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #(q);
        m_scl = 1'b1; #(q);
        m_sda = 1'b0; #(q);
        m_scl = 1'b0; #(q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #(q);
        m_scl = 1'b1; #(q);
        m_sda = 1'b1; #(q);
    endtask

    task automatic send_bit(input logic b, output logic s);
        m_sda = b;    #(q);
        m_scl = 1'b1; #(q);
        s = sda_bus;  #(q);
        m_scl = 1'b0; #(q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            d = {d[6:0], s};
        end
        send_bit(m_ack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int rx0, tx0, oe0;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_sda_oe",   sda_oe,   1'b0);
        chk("rst_tx_req",   tx_req,   1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy",     busy,     1'b0);
        chk("rst_rx_data",  rx_data,  8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write 0xA5 at 100 kHz
        rx0 = rxv_cnt;
        bus_start();
        chk("wr_busy", busy, 1'b1);
        write_byte(8'h34, ack);
        chk("wr_addr_ack", ack, 1'b0);
        write_byte(8'hA5, ack);
        chk("wr_data_ack", ack, 1'b0);
        chk("wr_rxv_count", rxv_cnt - rx0, 1);
        chk("wr_rx_data", rx_data, 8'hA5);
        bus_stop();
        repeat (10) @(negedge clk);
        chk("wr_busy_after_stop", busy, 1'b0);

        // Remaining traffic at 400 kHz
        q = 625;

        // Address mismatch
        rx0 = rxv_cnt; tx0 = txr_cnt; oe0 = oe_cnt;
        bus_start();
        write_byte(8'h36, ack);
        chk("mm_addr_nack", ack, 1'b1);
        write_byte(8'hFF, ack);
        chk("mm_data_nack", ack, 1'b1);
        bus_stop();
        repeat (10) @(negedge clk);
        chk("mm_oe_never", oe_cnt - oe0, 0);
        chk("mm_no_rxv", rxv_cnt - rx0, 0);
        chk("mm_no_txr", txr_cnt - tx0, 0);
        chk("mm_busy", busy, 1'b0);
        chk("mm_rx_data_held", rx_data, 8'hA5);

        // Two-byte read: ACK then NACK
        tx0 = txr_cnt;
        tx_data = 8'h5A;
        bus_start();
        write_byte(8'h35, ack);
        chk("rd_addr_ack", ack, 1'b0);
        chk("rd_txr_after_addr", txr_cnt - tx0, 1);
        tx_data = 8'hC3;
        read_byte(1'b0, d);
        chk("rd_byte0", d, 8'h5A);
        read_byte(1'b1, d);
        chk("rd_byte1", d, 8'hC3);
        chk("rd_txr_total", txr_cnt - tx0, 2);
        chk("rd_wait_stop_busy", busy, 1'b1);
        chk("rd_wait_stop_oe", sda_oe, 1'b0);
        bus_stop();
        repeat (10) @(negedge clk);
        chk("rd_idle", busy, 1'b0);

        // Repeated START: write 0x11 then read one byte
        rx0 = rxv_cnt; tx0 = txr_cnt;
        bus_start();
        write_byte(8'h34, ack);
        chk("sr_wr_addr_ack", ack, 1'b0);
        write_byte(8'h11, ack);
        chk("sr_wr_data_ack", ack, 1'b0);
        chk("sr_rx_data", rx_data, 8'h11);
        tx_data = 8'h3C;
        bus_start();
        write_byte(8'h35, ack);
        chk("sr_rd_addr_ack", ack, 1'b0);
        read_byte(1'b1, d);
        chk("sr_rd_byte", d, 8'h3C);
        bus_stop();
        repeat (10) @(negedge clk);
        chk("sr_txr_count", txr_cnt - tx0, 1);
        chk("sr_rxv_count", rxv_cnt - rx0, 1);
        chk("sr_rx_data_held", rx_data, 8'h11);

        // Reset during bit 4 of a read byte (0xA5: bit 4 is 0, SDA driven)
        tx_data = 8'hA5;
        bus_start();
        write_byte(8'h35, ack);
        chk("rs_addr_ack", ack, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, s);
        m_sda = 1'b1; #(q);
        m_scl = 1'b1; #(q);
        chk("rs_bit4_driven", sda_oe, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rs_oe_release", sda_oe,   1'b0);
        chk("rs_tx_req",     tx_req,   1'b0);
        chk("rs_rx_valid",   rx_valid, 1'b0);
        chk("rs_busy",       busy,     1'b0);
        chk("rs_rx_data",    rx_data,  8'h00);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        oe0 = oe_cnt;
        #(q);
        m_scl = 1'b0; #(q);
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        send_bit(1'b1, s);
        chk("rs_no_ack_bit", s, 1'b1);
        chk("rs_oe_quiet", oe_cnt - oe0, 0);
        chk("rs_idle", busy, 1'b0);
        bus_stop();
        bus_start();
        write_byte(8'h34, ack);
        chk("rs_new_start_ack", ack, 1'b0);
        bus_stop();
        repeat (10) @(negedge clk);
        chk("rs_final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
